// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: RAW stalls, taken-branch flush, immediate-word skip and halt.
// Defining FORWARDING_EN enables operand forwarding so that only load-use hazards stall.
module hazard_control_unit #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       id_rs1,
   input  logic [2:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_imm,
   input  logic             id_hlt,
   input  logic [2:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [2:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic             ex_branch_taken,
   output logic             freeze_pc,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_IMM    = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_HALTED = 3'd3
   } state_e;

   localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STALL_MAX  = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_count_q;
   logic [1:0]       fwd_a_q, fwd_b_q;
   logic [1:0]       fwd_a_d, fwd_b_d;
   logic             stall_inc;

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic raw_ex, raw_ex_load, hazard_stall;

   // Register 0 is an ordinary destination, so no zero-address exclusion.
   assign ex_hit_a  = ex_reg_write  & id_uses_rs1 & (ex_rd  == id_rs1);
   assign ex_hit_b  = ex_reg_write  & id_uses_rs2 & (ex_rd  == id_rs2);
   assign mem_hit_a = mem_reg_write & id_uses_rs1 & (mem_rd == id_rs1);
   assign mem_hit_b = mem_reg_write & id_uses_rs2 & (mem_rd == id_rs2);

   assign raw_ex      = ex_hit_a | ex_hit_b;
   assign raw_ex_load = raw_ex & ex_mem_read;

`ifdef FORWARDING_EN
   assign hazard_stall = raw_ex_load;
   assign fwd_a_d      = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
   assign fwd_b_d      = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
`else
   logic raw_ex_alu, raw_mem;
   assign raw_ex_alu   = raw_ex & ~ex_mem_read;
   assign raw_mem      = mem_hit_a | mem_hit_b;
   // Without bypass paths every RAW waits until the producer has left MEM.
   assign hazard_stall = raw_ex_load | raw_ex_alu | raw_mem;
   assign fwd_a_d      = 2'b00;
   assign fwd_b_d      = 2'b00;
`endif

   always_comb begin
      freeze_pc   = 1'b0;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_inc   = 1'b0;
      if (!reset) begin
         freeze_pc   = 1'b1;
         if_id_en    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_d     = ST_FLUSH;
         cnt_d       = FLUSH_LOAD;
      end else begin
         case (state_q)
            ST_HALTED: begin
               freeze_pc   = 1'b1;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
            ST_FLUSH: begin
               id_ex_flush = 1'b1;
               // A count of 1 (or 0 when FLUSH_CYCLES is 1) is the last bubble.
               if (cnt_q <= 3'd1) begin
                  cnt_d   = 3'd0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            ST_IMM: begin
               id_ex_flush = 1'b1;
               state_d     = ST_RUN;
            end
            default: begin
               if (hazard_stall) begin
                  freeze_pc   = 1'b1;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
                  stall_inc   = 1'b1;
               end else if (id_imm) begin
                  state_d = ST_IMM;
               end else if (id_hlt) begin
                  state_d = ST_HALTED;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         cnt_q         <= 3'd0;
         stall_count_q <= '0;
         fwd_a_q       <= 2'b00;
         fwd_b_q       <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (stall_inc && (stall_count_q != STALL_MAX)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
         end
         // A bubble entering ID/EX has no operands to forward.
         if (id_ex_flush) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
         end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
         end
      end
   end

   assign state       = state_q;
   assign stall_count = stall_count_q;
   assign fwd_a       = fwd_a_q;
   assign fwd_b       = fwd_b_q;

endmodule
